// File: rtl/peripheral_mpi_pkg.sv
// Shared definitions for the multi-channel MPI Wishbone endpoint:
// register indices, STATUS bit positions and the flit+last bundle.
package peripheral_mpi_pkg;

    localparam logic [2:0] REG_DATA      = 3'd0;
    localparam logic [2:0] REG_DATA_LAST = 3'd1;
    localparam logic [2:0] REG_STATUS    = 3'd2;
    localparam logic [2:0] REG_RX_SIZE   = 3'd3;
    localparam logic [2:0] REG_IRQ_EN    = 3'd4;

    localparam int ST_RX_AVAIL    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_RX_MSGS_LSB = 8;
    localparam int ST_TX_FREE_LSB = 16;

    localparam int MAX_FLIT_W = 32;

    typedef struct packed {
        logic                  last;
        logic [MAX_FLIT_W-1:0] flit;
    } mpi_flit_t;

    function automatic logic [31:0] status_word(
        input logic [7:0] tx_free,
        input logic [7:0] rx_msgs,
        input logic       tx_empty,
        input logic       tx_full,
        input logic       rx_avail
    );
        logic [31:0] w;
        w = '0;
        w[ST_TX_FREE_LSB +: 8] = tx_free;
        w[ST_RX_MSGS_LSB +: 8] = rx_msgs;
        w[ST_TX_EMPTY]         = tx_empty;
        w[ST_TX_FULL]          = tx_full;
        w[ST_RX_AVAIL]         = rx_avail;
        return w;
    endfunction

endpackage

// File: rtl/peripheral_mpi_fifo.sv
// Synchronous FIFO of flit+last entries, no fall-through.
// Ports: clk, rst (sync active-low), push_i/data_i/last_i, pop_i,
// data_o/last_o (head entry), count_o, full_o, empty_o.
// Push when full and pop when empty are ignored; full/empty are
// taken from the pre-edge state so push and pop may coincide.
module peripheral_mpi_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 data_i,
    input  logic                         last_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 data_o,
    output logic                         last_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [W:0]      mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign {last_o, data_o} = mem_q[rp_q];

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (do_push) wp_d = wp_q + 1'b1;
        if (do_pop)  rp_d = rp_q + 1'b1;
        if (do_push & ~do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (do_pop & ~do_push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= {last_i, data_i};
    end

endmodule

// File: rtl/peripheral_mpi_wb_mc.sv
// Multi-channel MPI endpoint: Wishbone slave with per-channel TX/RX
// flit buffers and one NoC port pair per channel, plus OR-ed irq.
// Ports: clk, rst (sync active-low); noc_out_* TX per channel;
// noc_in_* RX per channel; wb_* slave (adr[4:2] reg, adr[31:5] chan);
// irq = OR of (irq_en & rx_msgs != 0), registered.
module peripheral_mpi_wb_mc
    import peripheral_mpi_pkg::*;
#(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int SIZE           = 16,
    parameter int N              = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [N*NOC_FLIT_WIDTH-1:0] noc_out_flit,
    output logic [N-1:0]                noc_out_last,
    output logic [N-1:0]                noc_out_valid,
    input  logic [N-1:0]                noc_out_ready,
    input  logic [N*NOC_FLIT_WIDTH-1:0] noc_in_flit,
    input  logic [N-1:0]                noc_in_last,
    input  logic [N-1:0]                noc_in_valid,
    output logic [N-1:0]                noc_in_ready,
    input  logic [31:0]                 wb_adr_i,
    input  logic                        wb_we_i,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    input  logic [31:0]                 wb_dat_i,
    output logic [31:0]                 wb_dat_o,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic                        irq
);

    localparam int FW   = NOC_FLIT_WIDTH;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = $clog2(SIZE+1);
    localparam int AW   = $clog2(SIZE);

    logic            acc;
    logic [2:0]      reg_idx;
    logic [CW-1:0]   ch;
    logic            ch_ok;

    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     dat_q, dat_d;
    logic [N-1:0]    irq_en_q, irq_en_d;
    logic            irq_q, irq_d;

    mpi_flit_t       wb_flit;
    logic [FW-1:0]   wb_wdata;
    logic            push_last;
    logic [N-1:0]    tx_push;
    logic [N-1:0]    rx_pop;

    logic [N-1:0]    tx_full, tx_empty, tx_head_last, tx_pop;
    logic [N-1:0]    rx_full, rx_empty, rx_head_last, rx_push;
    logic [N-1:0]    rx_has;
    logic [FW-1:0]   tx_head [N];
    logic [FW-1:0]   rx_head [N];
    logic [CNTW-1:0] tx_cnt  [N];
    logic [CNTW-1:0] rx_cnt  [N];
    logic [CNTW-1:0] rx_msgs [N];
    logic [CNTW-1:0] rx_size [N];

    logic            unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    // Ack/err cycle blocks a new access so each strobe yields one pulse.
    assign acc     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign reg_idx = wb_adr_i[4:2];
    assign ch      = wb_adr_i[5 +: CW];
    // Whole upper field is compared so aliases of valid channels fail.
    assign ch_ok   = (32'(wb_adr_i[31:5]) < 32'(N));

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign irq      = irq_q;

    always_comb begin
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = '0;
        tx_push   = '0;
        rx_pop    = '0;
        push_last = 1'b0;
        irq_en_d  = irq_en_q;
        irq_d     = |(irq_en_q & rx_has);
        if (acc) begin
            err_d = 1'b1;
            if (ch_ok) begin
                unique case (1'b1)
                    reg_idx == REG_DATA: begin
                        if (wb_we_i) begin
                            if (!tx_full[ch]) begin
                                tx_push[ch] = 1'b1;
                                ack_d       = 1'b1;
                                err_d       = 1'b0;
                            end
                        end else if (!rx_empty[ch]) begin
                            rx_pop[ch] = 1'b1;
                            dat_d      = 32'(rx_head[ch]);
                            ack_d      = 1'b1;
                            err_d      = 1'b0;
                        end
                    end
                    reg_idx == REG_DATA_LAST: begin
                        if (wb_we_i && !tx_full[ch]) begin
                            tx_push[ch] = 1'b1;
                            push_last   = 1'b1;
                            ack_d       = 1'b1;
                            err_d       = 1'b0;
                        end
                    end
                    reg_idx == REG_STATUS: begin
                        if (!wb_we_i) begin
                            dat_d = status_word(
                                8'(SIZE) - 8'(tx_cnt[ch]),
                                8'(rx_msgs[ch]),
                                tx_empty[ch],
                                tx_full[ch],
                                rx_cnt[ch] != '0);
                            ack_d = 1'b1;
                            err_d = 1'b0;
                        end
                    end
                    reg_idx == REG_RX_SIZE: begin
                        if (!wb_we_i) begin
                            dat_d = 32'(rx_size[ch]);
                            ack_d = 1'b1;
                            err_d = 1'b0;
                        end
                    end
                    reg_idx == REG_IRQ_EN: begin
                        if (wb_we_i)
                            irq_en_d[ch] = wb_dat_i[0];
                        else
                            dat_d = {31'b0, irq_en_q[ch]};
                        ack_d = 1'b1;
                        err_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
        wb_flit.flit = wb_dat_i;
        wb_flit.last = push_last;
        wb_wdata     = wb_flit.flit[FW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_ch
        logic [CNTW-1:0] tx_msgs_q, tx_msgs_d;
        logic [CNTW-1:0] rx_msgs_q, rx_msgs_d;
        logic [CNTW-1:0] in_cnt_q, in_cnt_d;
        logic [CNTW-1:0] len_mem [SIZE];
        logic [AW-1:0]   len_wp_q, len_rp_q;
        logic            tx_inc, tx_dec;
        logic            rx_inc, rx_dec;

        peripheral_mpi_fifo #(.W(FW), .DEPTH(SIZE)) u_tx (
            .clk     (clk),
            .rst     (rst),
            .push_i  (tx_push[c]),
            .data_i  (wb_wdata),
            .last_i  (wb_flit.last),
            .pop_i   (tx_pop[c]),
            .data_o  (tx_head[c]),
            .last_o  (tx_head_last[c]),
            .count_o (tx_cnt[c]),
            .full_o  (tx_full[c]),
            .empty_o (tx_empty[c])
        );

        peripheral_mpi_fifo #(.W(FW), .DEPTH(SIZE)) u_rx (
            .clk     (clk),
            .rst     (rst),
            .push_i  (rx_push[c]),
            .data_i  (noc_in_flit[c*FW +: FW]),
            .last_i  (noc_in_last[c]),
            .pop_i   (rx_pop[c]),
            .data_o  (rx_head[c]),
            .last_o  (rx_head_last[c]),
            .count_o (rx_cnt[c]),
            .full_o  (rx_full[c]),
            .empty_o (rx_empty[c])
        );

        // TX only offered once a complete message sits in the buffer.
        assign noc_out_valid[c]         = (tx_msgs_q != '0);
        assign noc_out_flit[c*FW +: FW] = noc_out_valid[c] ? tx_head[c] : '0;
        assign noc_out_last[c]          = noc_out_valid[c] & tx_head_last[c];
        assign noc_in_ready[c]          = ~rx_full[c];

        assign tx_pop[c]  = noc_out_valid[c] & noc_out_ready[c];
        assign rx_push[c] = noc_in_valid[c] & ~rx_full[c];

        assign tx_inc = tx_push[c] & push_last;
        assign tx_dec = tx_pop[c] & tx_head_last[c];
        assign rx_inc = rx_push[c] & noc_in_last[c];
        assign rx_dec = rx_pop[c] & rx_head_last[c];

        assign rx_msgs[c] = rx_msgs_q;
        assign rx_has[c]  = (rx_msgs_q != '0);
        // Length FIFO holds one entry per complete message in RX.
        assign rx_size[c] = rx_has[c] ? len_mem[len_rp_q] : '0;

        always_comb begin
            tx_msgs_d = tx_msgs_q;
            rx_msgs_d = rx_msgs_q;
            in_cnt_d  = in_cnt_q;
            if (tx_inc & ~tx_dec)
                tx_msgs_d = tx_msgs_q + 1'b1;
            else if (tx_dec & ~tx_inc)
                tx_msgs_d = tx_msgs_q - 1'b1;
            if (rx_inc & ~rx_dec)
                rx_msgs_d = rx_msgs_q + 1'b1;
            else if (rx_dec & ~rx_inc)
                rx_msgs_d = rx_msgs_q - 1'b1;
            if (rx_push[c])
                in_cnt_d = noc_in_last[c] ? '0 : in_cnt_q + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                tx_msgs_q <= '0;
                rx_msgs_q <= '0;
                in_cnt_q  <= '0;
                len_wp_q  <= '0;
                len_rp_q  <= '0;
            end else begin
                tx_msgs_q <= tx_msgs_d;
                rx_msgs_q <= rx_msgs_d;
                in_cnt_q  <= in_cnt_d;
                if (rx_inc) len_wp_q <= len_wp_q + 1'b1;
                if (rx_dec) len_rp_q <= len_rp_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rx_inc) len_mem[len_wp_q] <= in_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_peripheral_mpi_wb_mc.sv
// Scoreboard bench for peripheral_mpi_wb_mc: stimulus queues expected
// WB responses, TX flits and level checks; one monitor compares them.
module tb_peripheral_mpi_wb_mc;

    localparam int FW = 32;
    localparam int SZ = 16;
    localparam int NC = 2;

    localparam int R_DATA   = 0;
    localparam int R_LAST   = 1;
    localparam int R_STATUS = 2;
    localparam int R_RXSIZE = 3;
    localparam int R_IRQEN  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NC*FW-1:0] noc_out_flit;
    logic [NC-1:0]    noc_out_last;
    logic [NC-1:0]    noc_out_valid;
    logic [NC-1:0]    noc_out_ready = '0;
    logic [NC*FW-1:0] noc_in_flit   = '0;
    logic [NC-1:0]    noc_in_last   = '0;
    logic [NC-1:0]    noc_in_valid  = '0;
    logic [NC-1:0]    noc_in_ready;
    logic [31:0]      wb_adr = '0;
    logic             wb_we  = 1'b0;
    logic             wb_cyc = 1'b0;
    logic             wb_stb = 1'b0;
    logic [31:0]      wb_wdat = '0;
    logic [31:0]      wb_rdat;
    logic             wb_ack;
    logic             wb_err;
    logic             irq;

    always #5 clk = ~clk;

    peripheral_mpi_wb_mc #(
        .NOC_FLIT_WIDTH(FW), .SIZE(SZ), .N(NC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noc_out_flit  (noc_out_flit),
        .noc_out_last  (noc_out_last),
        .noc_out_valid (noc_out_valid),
        .noc_out_ready (noc_out_ready),
        .noc_in_flit   (noc_in_flit),
        .noc_in_last   (noc_in_last),
        .noc_in_valid  (noc_in_valid),
        .noc_in_ready  (noc_in_ready),
        .wb_adr_i      (wb_adr),
        .wb_we_i       (wb_we),
        .wb_cyc_i      (wb_cyc),
        .wb_stb_i      (wb_stb),
        .wb_dat_i      (wb_wdat),
        .wb_dat_o      (wb_rdat),
        .wb_ack_o      (wb_ack),
        .wb_err_o      (wb_err),
        .irq           (irq)
    );

    typedef struct {
        bit          err;
        logic [31:0] dat;
        string       name;
    } wb_exp_t;

    typedef struct {
        int          ch;
        logic [31:0] flit;
        bit          last;
    } tx_exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    wb_exp_t wb_q[$];
    tx_exp_t tx_q[$];
    chk_t    chk_q[$];

    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        wb_exp_t we;
        tx_exp_t te;
        chk_t    ce;
        if (wb_ack || wb_err) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: ack=%0b err=%0b dat=%h, want none",
                         wb_ack, wb_err, wb_rdat);
            end else begin
                we = wb_q.pop_front();
                if (wb_err !== we.err || wb_ack !== !we.err || wb_rdat !== we.dat) begin
                    errors++;
                    $display("FAIL %s: ack=%0b err=%0b dat=%h, want err=%0b dat=%h",
                             we.name, wb_ack, wb_err, wb_rdat, we.err, we.dat);
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (noc_out_valid[c] && noc_out_ready[c]) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected ch%0d: flit=%h last=%0b, want none",
                             c, noc_out_flit[c*FW +: FW], noc_out_last[c]);
                end else begin
                    te = tx_q.pop_front();
                    if (te.ch != c || noc_out_flit[c*FW +: FW] !== te.flit ||
                        noc_out_last[c] !== te.last) begin
                        errors++;
                        $display("FAIL tx ch%0d: flit=%h last=%0b, want ch%0d flit=%h last=%0b",
                                 c, noc_out_flit[c*FW +: FW], noc_out_last[c],
                                 te.ch, te.flit, te.last);
                    end
                end
            end
        end
        while (chk_q.size() > 0) begin
            ce = chk_q.pop_front();
            checks++;
            if (ce.act !== ce.exp) begin
                errors++;
                $display("FAIL %s: got %h, want %h", ce.name, ce.act, ce.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_q.push_back('{nm, act, exp});
    endtask

    task automatic wb(input bit we, input int ch, input int r, input logic [31:0] d,
                      input bit xerr, input logic [31:0] xdat, input string nm);
        bit got;
        got = 1'b0;
        wb_q.push_back('{xerr, xdat, nm});
        wb_adr  = (32'(ch) << 5) | (32'(r) << 2);
        wb_we   = we;
        wb_wdat = d;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wb_ack | wb_err;
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        if (!got) begin
            wb_q.delete(wb_q.size() - 1);
            chk({"timeout ", nm}, 32'd0, 32'd1);
        end
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d,
                      input bit xerr, input string nm);
        wb(1'b1, ch, r, d, xerr, 32'd0, nm);
    endtask

    task automatic rd(input int ch, input int r, input bit xerr,
                      input logic [31:0] xdat, input string nm);
        wb(1'b0, ch, r, 32'd0, xerr, xdat, nm);
    endtask

    task automatic noc_send(input int ch, input logic [31:0] f, input bit l);
        bit done;
        done = 1'b0;
        noc_in_flit[ch*FW +: FW] = f;
        noc_in_last[ch]          = l;
        noc_in_valid[ch]         = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            done = noc_in_ready[ch];
            @(posedge clk);
            #1;
        end
        noc_in_valid[ch] = 1'b0;
        noc_in_last[ch]  = 1'b0;
        if (!done) chk("noc_send timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bit rdy;

        // Reset state
        rst = 1'b0;
        tick(2);
        chk("rst out_valid", 32'(noc_out_valid), 32'd0);
        chk("rst in_ready", 32'(noc_in_ready), 32'h3);
        chk("rst irq", 32'(irq), 32'd0);
        chk("rst ack", 32'(wb_ack), 32'd0);
        rst = 1'b1;
        tick(1);
        rd(0, R_STATUS, 1'b0, 32'h0010_0004, "rst status ch0");

        // Store-and-forward TX on channel 1
        noc_out_ready = 2'b10;
        wr(1, R_DATA, 32'hA, 1'b0, "tx1 data A");
        chk("tx1 no valid A", 32'(noc_out_valid[1]), 32'd0);
        wr(1, R_DATA, 32'hB, 1'b0, "tx1 data B");
        chk("tx1 no valid B", 32'(noc_out_valid[1]), 32'd0);
        tx_q.push_back('{1, 32'hA, 1'b0});
        tx_q.push_back('{1, 32'hB, 1'b0});
        tx_q.push_back('{1, 32'hC, 1'b1});
        wr(1, R_LAST, 32'hC, 1'b0, "tx1 last C");
        tick(5);
        chk("tx1 drained", 32'(tx_q.size()), 32'd0);
        chk("tx1 valid idle", 32'(noc_out_valid), 32'd0);

        // RX message on channel 0 with irq
        noc_send(0, 32'h11, 1'b0);
        noc_send(0, 32'h22, 1'b0);
        noc_send(0, 32'h33, 1'b1);
        wr(0, R_IRQEN, 32'd1, 1'b0, "irq_en ch0 wr");
        tick(2);
        chk("irq set", 32'(irq), 32'd1);
        rd(0, R_RXSIZE, 1'b0, 32'd3, "rx_size ch0");
        rd(0, R_STATUS, 1'b0, 32'h0010_0105, "status ch0 rx");
        rd(0, R_DATA, 1'b0, 32'h11, "rx0 flit 0");
        rd(0, R_DATA, 1'b0, 32'h22, "rx0 flit 1");
        rd(0, R_DATA, 1'b0, 32'h33, "rx0 flit 2");
        tick(2);
        chk("irq clear", 32'(irq), 32'd0);
        rd(0, R_RXSIZE, 1'b0, 32'd0, "rx_size ch0 empty");
        rd(0, R_IRQEN, 1'b0, 32'd1, "irq_en ch0 rd");

        // TX full and RX empty on channel 0
        for (int i = 0; i < SZ; i++)
            wr(0, R_DATA, 32'(i), 1'b0, "tx0 fill");
        wr(0, R_DATA, 32'hFF, 1'b1, "tx0 overflow data");
        wr(0, R_LAST, 32'hFF, 1'b1, "tx0 overflow last");
        rd(0, R_STATUS, 1'b0, 32'h0000_0002, "status ch0 full");
        chk("tx0 uncommitted", 32'(noc_out_valid[0]), 32'd0);
        rd(0, R_DATA, 1'b1, 32'd0, "rx0 empty read");

        // RX backpressure on channel 1
        acc = 0;
        noc_in_valid[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            noc_in_flit[FW +: FW] = 32'h100 + 32'(acc);
            noc_in_last[1]        = (acc == 15);
            rdy = noc_in_ready[1];
            tick(1);
            if (rdy) acc++;
        end
        noc_in_valid[1] = 1'b0;
        noc_in_last[1]  = 1'b0;
        chk("rx1 accepted", 32'(acc), 32'd16);
        chk("rx1 ready full", 32'(noc_in_ready[1]), 32'd0);
        chk("rx0 ready", 32'(noc_in_ready[0]), 32'd1);
        rd(1, R_STATUS, 1'b0, 32'h0010_0105, "status ch1 rx full");
        rd(1, R_RXSIZE, 1'b0, 32'd16, "rx_size ch1");
        rd(1, R_DATA, 1'b0, 32'h100, "rx1 flit 0");
        noc_in_flit[FW +: FW] = 32'h110;
        noc_in_valid[1]       = 1'b1;
        rd(1, R_DATA, 1'b0, 32'h101, "rx1 flit 1 simul");
        noc_in_valid[1] = 1'b0;
        chk("rx1 ready after simul", 32'(noc_in_ready[1]), 32'd1);
        noc_send(1, 32'h111, 1'b0);
        chk("rx1 ready refull", 32'(noc_in_ready[1]), 32'd0);
        for (int i = 2; i < 16; i++)
            rd(1, R_DATA, 1'b0, 32'h100 + 32'(i), "rx1 drain");
        rd(1, R_RXSIZE, 1'b0, 32'd0, "rx_size ch1 partial");
        rd(1, R_STATUS, 1'b0, 32'h0010_0005, "status ch1 partial");
        rd(1, R_DATA, 1'b0, 32'h110, "rx1 partial 0");
        rd(1, R_DATA, 1'b0, 32'h111, "rx1 partial 1");
        rd(1, R_DATA, 1'b1, 32'd0, "rx1 empty read");

        // Decode errors
        rd(5, R_STATUS, 1'b1, 32'd0, "bad channel");
        rd(0, 7, 1'b1, 32'd0, "bad reg");
        wr(0, R_STATUS, 32'hFFFF_FFFF, 1'b1, "write status");
        wr(0, R_RXSIZE, 32'h1, 1'b1, "write rx_size");
        rd(0, R_LAST, 1'b1, 32'd0, "read data_last");

        // Reset in the middle of a pending TX message
        noc_out_ready = 2'b00;
        wr(1, R_DATA, 32'h1, 1'b0, "tx1 pend data");
        wr(1, R_LAST, 32'h2, 1'b0, "tx1 pend last");
        tick(1);
        chk("tx1 pending valid", 32'(noc_out_valid), 32'h2);
        rst = 1'b0;
        tick(1);
        chk("mid rst valid", 32'(noc_out_valid), 32'd0);
        chk("mid rst ready", 32'(noc_in_ready), 32'h3);
        rst = 1'b1;
        noc_out_ready = 2'b11;
        tick(4);
        rd(0, R_STATUS, 1'b0, 32'h0010_0004, "post rst status ch0");
        rd(1, R_STATUS, 1'b0, 32'h0010_0004, "post rst status ch1");
        rd(0, R_IRQEN, 1'b0, 32'd0, "post rst irq_en");
        chk("post rst irq", 32'(irq), 32'd0);

        tick(3);
        chk("queues empty", 32'(wb_q.size() + tx_q.size()), 32'd0);
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
